// File: rtl/midi_pkg.sv
// Shared MIDI constants and helpers: bit-period derivation, status classes,
// and message data-length lookup.
package midi_pkg;

  localparam logic [7:0] ST_REALTIME_MIN = 8'hF8;
  localparam logic [7:0] ST_SYSCOM_MIN   = 8'hF0;

  function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                               input int unsigned baud);
    return clk_hz / baud;
  endfunction

  // Program change and channel pressure carry one data byte; the rest carry two.
  function automatic logic [1:0] midi_data_len(input logic [7:0] status);
    return (status[7:4] == 4'hC || status[7:4] == 4'hD) ? 2'd1 : 2'd2;
  endfunction

endpackage

// File: rtl/midi_uart_rx.sv
// 8N1 serial receiver: 2-flop synchronizer, mid-bit sampling FSM, and
// one-cycle pulses for received byte, framing error and confirmed start.
module midi_uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 1600
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       rx_in,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       Frame_err,
  output logic       Activity
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF_LD = CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [CW-1:0] BIT_LD  = CW'(CLKS_PER_BIT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]    sync;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bitn;
  logic [7:0]    shreg;
  logic          rxs;

  assign rxs = sync[1];

  // Synchronizer resets high so a released reset never looks like a start bit.
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) sync <= 2'b11;
    else        sync <= {sync[0], rx_in};

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bitn      <= '0;
      shreg     <= '0;
      rx_byte   <= '0;
      rx_valid  <= 1'b0;
      Frame_err <= 1'b0;
      Activity  <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      Frame_err <= 1'b0;
      Activity  <= 1'b0;
      case (state)
        S_IDLE:
          if (!rxs) begin
            state <= S_START;
            cnt   <= HALF_LD;
          end
        S_START:
          if (cnt != '0) cnt <= cnt - 1'b1;
          else if (!rxs) begin
            Activity <= 1'b1;
            state    <= S_DATA;
            cnt      <= BIT_LD;
            bitn     <= '0;
          end else state <= S_IDLE;
        S_DATA:
          if (cnt != '0) cnt <= cnt - 1'b1;
          else begin
            shreg <= {rxs, shreg[7:1]};
            cnt   <= BIT_LD;
            if (bitn == 3'd7) state <= S_STOP;
            else              bitn  <= bitn + 1'b1;
          end
        default:
          if (cnt != '0) cnt <= cnt - 1'b1;
          else begin
            if (rxs) begin
              rx_byte  <= shreg;
              rx_valid <= 1'b1;
            end else Frame_err <= 1'b1;
            state <= S_IDLE;
          end
      endcase
    end
  end

endmodule

// File: rtl/midi_msg_assembler.sv
// MIDI channel-voice message assembler: receives serial bytes and builds
// {status, data1, data2} words with running status and real-time filtering.
module midi_msg_assembler
  import midi_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned BAUD         = 31_250,
  parameter int unsigned CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD)
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        MIDI_in,
  output logic [23:0] MIDI_data,
  output logic        Msg_valid,
  output logic        Frame_err,
  output logic        Activity
);

  logic [7:0] rx_byte;
  logic       rx_valid, rx_ferr, rx_act;

  logic [7:0] run_status;
  logic [1:0] need;
  logic       idx;
  logic [7:0] d1;

  midi_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .rx_in     (MIDI_in),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .Frame_err (rx_ferr),
    .Activity  (rx_act)
  );

  // Activity/Frame_err are retimed by one cycle so all three outputs share
  // the same latency from their sample point.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      MIDI_data  <= '0;
      Msg_valid  <= 1'b0;
      Frame_err  <= 1'b0;
      Activity   <= 1'b0;
      run_status <= '0;
      need       <= 2'd2;
      idx        <= 1'b0;
      d1         <= '0;
    end else begin
      Msg_valid <= 1'b0;
      Frame_err <= rx_ferr;
      Activity  <= rx_act;
      if (rx_ferr) begin
        idx <= 1'b0;
      end else if (rx_valid) begin
        if (rx_byte >= ST_REALTIME_MIN) begin
          // real-time bytes are transparent to message assembly
        end else if (rx_byte >= ST_SYSCOM_MIN) begin
          run_status <= '0;
          idx        <= 1'b0;
        end else if (rx_byte[7]) begin
          run_status <= rx_byte;
          idx        <= 1'b0;
          need       <= midi_data_len(rx_byte);
        end else if (run_status != 8'h00) begin
          if (!idx) begin
            d1 <= rx_byte;
            if (need == 2'd1) begin
              MIDI_data <= {run_status, rx_byte, 8'h00};
              Msg_valid <= 1'b1;
            end else idx <= 1'b1;
          end else begin
            MIDI_data <= {run_status, d1, rx_byte};
            Msg_valid <= 1'b1;
            idx       <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: doc/midi_msg_assembler.md
# midi_msg_assembler

Receives the raw MIDI serial line (31 250 baud, 8N1, idle high) and assembles complete channel-voice messages into the 24-bit `{status, data1, data2}` word consumed by `mux_NoteOnOff` and `ChannelSel`. It sits directly upstream of the note/channel routing stage. It handles running status, system real-time and system-common bytes, and two-byte messages. It also signals framing errors and line activity, which feed the enable timeout.

## Interface
- `CLK_HZ`, default 50_000_000, system clock frequency.
- `BAUD`, default 31_250, MIDI bit rate.
- `CLKS_PER_BIT`, default `CLK_HZ/BAUD` (1600), clocks per serial bit.
- `Clk`, in, 1, system clock. One clock domain; all logic on the rising edge.
- `Rst_n`, in, 1, reset. Asynchronous, active-low.
- `MIDI_in`, in, 1, asynchronous serial input, idle high.
- `MIDI_data`, out, 24, last assembled message `{status, data1, data2}`. Held until the next message.
- `Msg_valid`, out, 1, one-cycle pulse. `MIDI_data` is updated in the same cycle.
- `Frame_err`, out, 1, one-cycle pulse. Stop bit was sampled low.
- `Activity`, out, 1, one-cycle pulse per confirmed start bit.

## Operation
- Input path: 2-flop synchronizer. Both flops reset to 1, so no false start bit after reset.
- Receiver FSM states:
  - `IDLE`: synced input low → `START`. Bit counter loads `CLKS_PER_BIT/2-1`.
  - `START`: at mid-bit, input low → pulse `Activity`, go to `DATA`. Input high → glitch; return to `IDLE` with no pulse.
  - `DATA`: sample every `CLKS_PER_BIT`, LSB first, 8 bits.
  - `STOP`: sample at mid-bit. High → `byte_valid`. Low → pulse `Frame_err` and discard the byte. Either way go to `IDLE` in the next cycle, so back-to-back bytes work.
- Parser state:
  - `run_status`, 8 bits; 0x00 means none.
  - `need`, 1 or 2: the number of data bytes the message takes.
  - `idx`, 0 or 1.
  - `d1`, 8 bits.
- Per-byte rules:
  - 0xF8–0xFF (real-time): ignored. No parser state changes.
  - 0xF0–0xF7 (system common/SysEx): `run_status` ← 0x00 and `idx` ← 0. Following data bytes are ignored.
  - 0x80–0xEF: `run_status` ← byte and `idx` ← 0. `need` = 1 for 0xC_/0xD_, otherwise 2.
  - Data byte (<0x80) with `run_status` = 0x00: ignored.
  - Data byte with `idx` = 0: `d1` ← byte. If `need` = 1, emit `{run_status, byte, 8'h00}`; otherwise `idx` ← 1.
  - Data byte with `idx` = 1: emit `{run_status, d1, byte}` and set `idx` ← 0. `run_status` is retained.
- Frame error:
  - `idx` ← 0, dropping any partial message.
  - `run_status` is retained.
  - A corrupted status byte is never latched.
- Note-on with velocity 0 passes through unchanged; downstream handles it.

## Timing
- Reset values:
  - `MIDI_data` = 24'h000000.
  - `Msg_valid`, `Frame_err`, `Activity` = 0.
  - FSM in `IDLE`.
  - `run_status` = 0x00, `idx` = 0.
- Cycle 0 is the first `Clk` edge at which the pin is low.
- Sample points: cycle `2 + CLKS_PER_BIT/2 + k·CLKS_PER_BIT`.
  - k = 0: start bit.
  - k = 1..8: data bits.
  - k = 9: stop bit.
- With defaults:
  - `Activity` pulses at cycle 803.
  - Stop bit is sampled at cycle 15202.
  - `Msg_valid`/`Frame_err` pulse at cycle 15203.
- `Msg_valid` and `Frame_err` are never high in the same cycle.
- Asserting reset mid-byte clears all state immediately. On release, the first low sample starts a fresh frame.
- `CLKS_PER_BIT` counter width is `$clog2(CLKS_PER_BIT)`. It never wraps mid-bit.

## Structure
- Shared package `midi_pkg` holds:
  - `CLKS_PER_BIT` derivation.
  - Status-class constants (`ST_REALTIME_MIN` = 0xF8, `ST_SYSCOM_MIN` = 0xF0).
  - Function `midi_data_len(status)` returning 1 or 2.
- Sub-module `midi_uart_rx` contains the synchronizer, receiver FSM and bit counter. Its outputs are `rx_byte[7:0]`, `rx_valid`, `Frame_err`, `Activity`.
- The parser lives in `midi_msg_assembler`.

## Test plan
- **Basic note-on:** 0x90 0x3C 0x64 at 31 250 baud → exactly one `Msg_valid`, `MIDI_data` = 24'h903C64. The pulse lands 15203 cycles after the third byte's start edge.
- **Running status:** 0x91 0x40 0x7F 0x43 0x00 → two pulses, 24'h91407F then 24'h914300.
- **Real-time interleave:** 0x80, 0xF8, 0x3C, 0xFE, 0x00 → one pulse, 24'h803C00.
- **Two-byte messages and SysEx:**
  - 0xC2 0x05 → 24'hC20500.
  - Then 0xF0 0x7E 0x01 0xF7 0x20 0x30 → no `Msg_valid`.
  - After reset, 0x3C 0x64 → no `Msg_valid`.
- **Framing error and glitch rejection:**
  - After reset, 0x90 with stop bit driven 0 → `Frame_err` pulse, no `Msg_valid`. Then 0x3C 0x64 → no `Msg_valid`.
  - A 400-cycle low glitch → no `Activity`, no byte.
- **Reset mid-byte:** `Rst_n` low during data bit 4 → all outputs 0 within the reset cycle. After release, 0x92 0x45 0x50 → 24'h924550.
